cpu_mem_responder: RTL and testbench

//  Memory-side responder for cpu_multicycle_v1's unified instr/data port (mem_addr, mem_wr_en, mem_data_in -> mem_data_out).

---
 rtl/cpu_mem_responder_if.sv | 22 ++
 rtl/cpu_mem_responder.sv | 73 +++++++
 tb/tb_cpu_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU unified memory bus plus valid/ready program-load port
interface cpu_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  modport master (
    output mem_wr_en, mem_addr, mem_data_in, load_valid, load_data, load_last,
    input  mem_data_out, load_ready
  );
  modport slave (
    input  mem_wr_en, mem_addr, mem_data_in, load_valid, load_data, load_last,
    output mem_data_out, load_ready
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word RAM for the CPU that boots via a load port while holding the CPU in reset (optional MEM_ACCESS_FAULT_EN)
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  cpu_mem_responder_if.slave       bus,
  output logic                     cpu_rst_n,
  output logic [$clog2(DEPTH):0]   load_count
`ifdef MEM_ACCESS_FAULT_EN
  ,
  output logic                     mem_fault
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  logic [1:0]            r_state;
  logic [AW-1:0]         r_load_ptr;
  logic [AW:0]           r_load_count;
  logic                  r_load_ready;
  logic                  r_cpu_rst_n;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         w_idx;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_bad;
  logic                  w_cpu_we;
  assign w_idx    = bus.mem_addr[AW+1:2];
  assign w_accept = (r_state == LOAD) && bus.load_valid && r_load_ready;
  assign w_done   = w_accept && (bus.load_last || r_load_ptr == AW'(DEPTH-1));
`ifdef MEM_ACCESS_FAULT_EN
  logic r_mem_fault;
  assign w_bad = (r_state == RUN) &&
                 (bus.mem_addr >= ADDR_WIDTH'(4*DEPTH) || |bus.mem_addr[1:0]);
  // sticky fault flag, cleared only by system reset
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_mem_fault <= 1'b0;
    else            r_mem_fault <= r_mem_fault | w_bad;
  assign mem_fault = r_mem_fault;
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign w_unused = ^{bus.mem_addr[ADDR_WIDTH-1:AW+2], bus.mem_addr[1:0]};
`endif
  assign w_cpu_we         = bus.mem_wr_en && (r_state == RUN) && !w_bad;
  assign bus.mem_data_out = w_bad ? '0 : r_mem[w_idx];
  assign bus.load_ready   = r_load_ready;
  assign cpu_rst_n        = r_cpu_rst_n;
  assign load_count       = r_load_count;
  // boot sequencer: load words, one settling cycle, then release the CPU
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state      <= LOAD;
      r_load_ptr   <= '0;
      r_load_count <= '0;
      r_load_ready <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
    end else begin
      r_state      <= (r_state == LOAD) ? (w_done ? RELEASE : LOAD) : RUN;
      r_load_ptr   <= w_accept ? r_load_ptr + 1'b1 : r_load_ptr;
      r_load_count <= w_accept ? r_load_count + 1'b1 : r_load_count;
      r_load_ready <= (r_state == LOAD) && !w_done;
      r_cpu_rst_n  <= (r_state != LOAD);
    end
  // single write port shared by loader (LOAD only) and CPU (RUN only)
  always_ff @(posedge sys_clk)
    if (w_accept)      r_mem[r_load_ptr] <= bus.load_data;
    else if (w_cpu_we) r_mem[w_idx]      <= bus.mem_data_in;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
  localparam int DEPTH = 16;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cpu_rst_n;
  logic [4:0] load_count;
  int checks = 0;
  int errors = 0;
`ifdef MEM_ACCESS_FAULT_EN
  logic mem_fault;
`endif
  cpu_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  cpu_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus),
    .cpu_rst_n(cpu_rst_n),
    .load_count(load_count)
`ifdef MEM_ACCESS_FAULT_EN
    ,
    .mem_fault(mem_fault)
`endif
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    @(negedge sys_clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_addr = a;
    #1;
    check(tag, bus.mem_data_out, exp);
  endtask
  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask
  initial begin
    bus.mem_wr_en = 1'b0; bus.mem_addr = '0; bus.mem_data_in = '0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_ready", {31'd0, bus.load_ready}, 32'd0);
    check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_count", {27'd0, load_count}, 32'd0);
    sys_rst_n = 1'b1;
    #1 check("ready_reg", {31'd0, bus.load_ready}, 32'd0);
    @(negedge sys_clk);
    check("ready_rise", {31'd0, bus.load_ready}, 32'd1);
    // full-depth load with CPU write strobe held active (must be gated)
    bus.mem_wr_en = 1'b1; bus.mem_addr = '0; bus.mem_data_in = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i, 1'b0);
    bus.mem_wr_en = 1'b0;
    check("full_count", {27'd0, load_count}, DEPTH);
    check("full_ready_drop", {31'd0, bus.load_ready}, 32'd0);
    check("full_release", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge sys_clk);
    check("full_run", {31'd0, cpu_rst_n}, 32'd1);
    rd("full_ram0", 32'h0, 32'h100);
    rd("full_ram15", 32'h3C, 32'h10F);
    rd("full_ram4", 32'h10, 32'h104);
    // CPU write in RUN: old data before edge, new data after
    bus.mem_addr = 32'h10; bus.mem_data_in = 32'hDEAD_BEEF; bus.mem_wr_en = 1'b1;
    #1 check("wr_old", bus.mem_data_out, 32'h104);
    @(negedge sys_clk);
    bus.mem_wr_en = 1'b0;
    check("wr_new", bus.mem_data_out, 32'hDEAD_BEEF);
    // write to 4*DEPTH
    bus.mem_addr = 32'h40; bus.mem_data_in = 32'hCAFE_0001; bus.mem_wr_en = 1'b1;
    @(negedge sys_clk);
    bus.mem_wr_en = 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
    check("fault_flag", {31'd0, mem_fault}, 32'd1);
    rd("fault_ram0", 32'h0, 32'h100);
`else
    rd("alias_ram0", 32'h0, 32'hCAFE_0001);
    rd("alias_read", 32'h43, 32'hCAFE_0001);
`endif
    // short load with last on 4th word
    do_reset();
    check("t1_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    check("t1_count0", {27'd0, load_count}, 32'd0);
    push(32'hA0, 1'b0); push(32'hA1, 1'b0); push(32'hA2, 1'b0); push(32'hA3, 1'b1);
    check("t1_count", {27'd0, load_count}, 32'd4);
    check("t1_ready", {31'd0, bus.load_ready}, 32'd0);
    check("t1_release", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge sys_clk);
    check("t1_run", {31'd0, cpu_rst_n}, 32'd1);
    rd("t1_ram0", 32'h0, 32'hA0);
    rd("t1_ram1", 32'h4, 32'hA1);
    rd("t1_ram2", 32'h8, 32'hA2);
    rd("t1_ram3", 32'hC, 32'hA3);
    rd("t1_ram4_kept", 32'h10, 32'hDEAD_BEEF);
    // valid gap, and load_last without valid is ignored
    do_reset();
    push(32'hB0, 1'b0);
    bus.load_data = 32'hBAD; bus.load_last = 1'b1;
    @(negedge sys_clk);
    bus.load_last = 1'b0;
    check("t2_gap_count", {27'd0, load_count}, 32'd1);
    check("t2_gap_ready", {31'd0, bus.load_ready}, 32'd1);
    push(32'hB1, 1'b1);
    check("t2_count", {27'd0, load_count}, 32'd2);
    rd("t2_ram0", 32'h0, 32'hB0);
    rd("t2_ram1", 32'h4, 32'hB1);
    rd("t2_ram2", 32'h8, 32'hA2);
    // loader ignored once released
    @(negedge sys_clk);
    push(32'hEE, 1'b1);
    check("t2_run_count", {27'd0, load_count}, 32'd2);
    rd("t2_run_ram2", 32'h8, 32'hA2);
    // reset mid-load
    do_reset();
    push(32'hC0, 1'b0); push(32'hC1, 1'b0);
    check("t5_count2", {27'd0, load_count}, 32'd2);
    sys_rst_n = 1'b0;
    #1;
    check("t5_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    check("t5_count_clr", {27'd0, load_count}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    push(32'hD0, 1'b1);
    check("t5_count", {27'd0, load_count}, 32'd1);
    rd("t5_ram0", 32'h0, 32'hD0);
    rd("t5_ram1", 32'h4, 32'hC1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
